// File: rtl/pattern_recognizer_param_pkg.sv
// Shared constants for the parametrised serial pattern recognizer.
package pattern_recognizer_param_pkg;
    localparam int unsigned DEF_N         = 4;
    localparam int unsigned DEF_CNT_W     = 8;
    localparam logic [3:0]  DEF_PATTERN_4 = 4'b1101;
    localparam logic        OVERLAP_ON    = 1'b1;
    localparam logic        OVERLAP_OFF   = 1'b0;
endpackage

// File: rtl/pattern_recognizer_param_sat_counter.sv
// Saturating event counter; a clear and an increment in the same cycle yields 1.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         sat
);
    localparam logic [W-1:0] MAX = {W{1'b1}};

    logic [W-1:0] count_q, count_d;
    logic         sat_q, sat_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? W'(1) : '0;
        end else if (inc && (count_q != MAX)) begin
            count_d = count_q + W'(1);
        end
        sat_d = (count_d == MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count = count_q;
    assign sat   = sat_q;
endmodule

// File: rtl/pattern_recognizer_param.sv
// Serial pattern recognizer: N-bit shift window vs. loadable masked pattern,
// with fill guard, overlap/non-overlap mode and a saturating match counter.
module pattern_recognizer_param
    import pattern_recognizer_param_pkg::*;
#(
    parameter int unsigned    N           = DEF_N,
    parameter int unsigned    CNT_W       = DEF_CNT_W,
    parameter logic [N-1:0]   DEF_PATTERN = N'(DEF_PATTERN_4),
    parameter logic [N-1:0]   DEF_MASK    = {N{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             string_in,
    input  logic             valid_in,
    input  logic             load,
    input  logic [N-1:0]     pattern_in,
    input  logic [N-1:0]     mask_in,
    input  logic             overlap,
    input  logic             clr_count,
    output logic             seen,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);
    localparam int unsigned  FILL_W   = $clog2(N + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(N);

    logic [N-1:0]      win_q, win_d, pat_q, pat_d, mask_q, mask_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              seen_q, seen_d;
    logic [N-1:0]      win_shift;
    logic [FILL_W-1:0] fill_inc;
    logic              hit_c;

    assign win_shift = {win_q[N-2:0], string_in};
    assign fill_inc  = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
    // Only a full window of real bits may match; masked-off bits are ignored.
    assign hit_c     = valid_in && !load && (fill_inc == FILL_MAX)
                       && (((win_shift ^ pat_q) & mask_q) == '0);

    always_comb begin
        win_d  = win_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        mask_d = mask_q;
        seen_d = 1'b0;
        if (load) begin
            pat_d  = pattern_in;
            mask_d = mask_in;
            win_d  = '0;
            fill_d = '0;
        end else if (valid_in) begin
            win_d  = win_shift;
            fill_d = (hit_c && (overlap == OVERLAP_OFF)) ? '0 : fill_inc;
            seen_d = hit_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q  <= '0;
            fill_q <= '0;
            pat_q  <= DEF_PATTERN;
            mask_q <= DEF_MASK;
            seen_q <= 1'b0;
        end else begin
            win_q  <= win_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            mask_q <= mask_d;
            seen_q <= seen_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_count),
        .inc   (hit_c),
        .count (match_count),
        .sat   (count_sat)
    );

    assign seen = seen_q;
endmodule

// File: tb/tb_pattern_recognizer_param.sv
// Directed and randomized bench for pattern_recognizer_param against a history-based model.
module tb_pattern_recognizer_param;
    import pattern_recognizer_param_pkg::*;

    localparam int unsigned N     = 4;
    localparam int unsigned CNT_W = 2;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             string_in, valid_in, load, overlap, clr_count;
    logic [N-1:0]     pattern_in, mask_in;
    logic             seen;
    logic [CNT_W-1:0] match_count;
    logic             count_sat;

    int errors = 0;
    int checks = 0;

    // Model state: accepted bits since the last restart, fresh-bit count, pattern, counter.
    bit     hist[$];
    int     since;
    bit [N-1:0] m_pat, m_mask;
    int     exp_cnt;
    bit     exp_seen;

    pattern_recognizer_param #(.N(N), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .string_in   (string_in),
        .valid_in    (valid_in),
        .load        (load),
        .pattern_in  (pattern_in),
        .mask_in     (mask_in),
        .overlap     (overlap),
        .clr_count   (clr_count),
        .seen        (seen),
        .match_count (match_count),
        .count_sat   (count_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        since    = 0;
        m_pat    = 4'b1101;
        m_mask   = '1;
        exp_cnt  = 0;
        exp_seen = 0;
    endtask

    function automatic bit model_match();
        bit ok = (since >= N);
        if (ok) begin
            for (int i = 0; i < N; i++) begin
                if (m_mask[i] && (hist[hist.size() - 1 - i] != m_pat[i])) ok = 0;
            end
        end
        return ok;
    endfunction

    // Apply one cycle of inputs, advance the model, then check after the edge.
    task automatic cyc(input string tag, input bit v, input bit b, input bit ld,
                       input bit [N-1:0] p, input bit [N-1:0] m,
                       input bit ov, input bit clr);
        bit hit;
        valid_in = v; string_in = b; load = ld; pattern_in = p; mask_in = m;
        overlap = ov; clr_count = clr;
        hit = 0;
        if (ld) begin
            m_pat = p; m_mask = m;
            hist.delete();
            since = 0;
        end else if (v) begin
            hist.push_back(b);
            if (hist.size() > N) void'(hist.pop_front());
            since++;
            hit = model_match();
            if (hit && ov == OVERLAP_OFF) since = 0;
        end
        exp_seen = hit;
        if (clr) exp_cnt = hit ? 1 : 0;
        else if (hit && exp_cnt < CMAX) exp_cnt++;
        @(posedge clk);
        #1;
        check({tag, "_seen"}, int'(seen), int'(exp_seen));
        check({tag, "_cnt"}, int'(match_count), exp_cnt);
        check({tag, "_sat"}, int'(count_sat), int'(exp_cnt == CMAX));
    endtask

    task automatic stream(input string tag, input bit [6:0] bits, input int len,
                          input bit [N-1:0] p, input bit [N-1:0] m, input bit ov);
        for (int i = len - 1; i >= 0; i--) cyc(tag, 1'b1, bits[i], 1'b0, p, m, ov, 1'b0);
    endtask

    initial begin
        bit [6:0] s;
        reset = 1'b1;
        {string_in, valid_in, load, overlap, clr_count} = '0;
        pattern_in = '0; mask_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_seen", int'(seen), 0);
        check("rst_cnt", int'(match_count), 0);
        check("rst_sat", int'(count_sat), 0);
        @(negedge clk);
        reset = 1'b0;

        s = 7'b1101101;
        stream("ov1", s, 7, '0, '0, 1'b1);
        check("ov1_total", int'(match_count), 2);

        cyc("clr", 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
        stream("ov0", s, 7, '0, '0, 1'b0);
        check("ov0_total", int'(match_count), 1);

        cyc("ld0", 1'b1, 1'b0, 1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1);
        stream("fill", 7'b0000000, 3, '0, '0, 1'b1);
        check("fill_guard", int'(seen), 0);
        cyc("fill4", 1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        check("fill4_seen", int'(seen), 1);

        cyc("ld9", 1'b0, 1'b0, 1'b1, 4'b1001, 4'b1001, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc("gap", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
            cyc("m9", 1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        end
        check("m9_seen", int'(seen), 1);

        cyc("ldm0", 1'b0, 1'b0, 1'b1, 4'b0110, 4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) cyc("sat", 1'b1, 1'($urandom), 1'b0, '0, '0, 1'b1, 1'b0);
        check("sat_cnt", int'(match_count), 3);
        check("sat_flag", int'(count_sat), 1);
        cyc("clrhit", 1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
        check("clrhit_cnt", int'(match_count), 1);
        check("clrhit_sat", int'(count_sat), 0);

        cyc("ld13", 1'b0, 1'b0, 1'b1, 4'b1101, 4'b1111, 1'b1, 1'b0);
        stream("pre", 7'b0000110, 3, '0, '0, 1'b1);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check("arst_seen", int'(seen), 0);
        check("arst_cnt", int'(match_count), 0);
        check("arst_sat", int'(count_sat), 0);
        @(negedge clk);
        reset = 1'b0;
        cyc("post1", 1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        check("post1_seen", int'(seen), 0);
        stream("post", 7'b0000101, 3, '0, '0, 1'b1);
        check("post_seen", int'(seen), 1);

        for (int i = 0; i < 600; i++) begin
            cyc("rnd", ($urandom_range(3) != 0), 1'($urandom), ($urandom_range(31) == 0),
                N'($urandom), N'($urandom & $urandom), 1'($urandom),
                ($urandom_range(23) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
